twi_master: RTL and testbench
=============================

// Module: twi_master
// PURPOSE
//  Single-byte TWI (I2C) bus initiator; the counterpart of the team's TWI slave.
//  Per request: START, 7-bit address + R/W, one data byte (written, or read and NACKed), STOP.
//  Sits between fabric logic (start/done handshake) and the SCL/SDA pads (SDA open-drain via sdaOutEn).
//  Used to exercise twi_slave on-chip and to talk to external TWI peripherals.
// PARAMETERS
//  CLK_DIV  30  clk cycles per quarter bit-time (>=4); SCL period = 4*CLK_DIV (12 MHz -> 100 kHz)
// PORTS
//  clk       in   1  system clock; sole clock domain
//  reset     in   1  synchronous, active-high reset
//  start     in   1  request pulse; accepted only when busy=0
//  addr      in   7  target address; latched on accept
//  rw        in   1  1=read byte from target, 0=write txData; latched on accept
//  txData    in   8  byte to write; latched on accept
//  rxData    out  8  byte read; valid from done pulse until next accept
//  busy      out  1  high from cycle after accept through last STOP cycle
//  done      out  1  one-cycle pulse on completion
//  nack      out  1  valid with done: 1 = address or write-data not acknowledged
//  scl       out  1  SCL drive (push-pull, no clock stretching)
//  sdaIn     in   1  SDA pad input (asynchronous)
//  sdaOut    out  1  SDA drive value, always 0
//  sdaOutEn  out  1  1 = pull SDA low, 0 = release
// BEHAVIOUR
//  Reset (any cycle, incl. mid-transfer): scl=1, sdaOut=0, sdaOutEn=0, busy=0, done=0, nack=0,
//   rxData=0, state=IDLE, counters=0. Bus released immediately; no STOP generated.
//  sdaIn: 2-FF synchronizer; all sampling uses the synchronized value.
//  Bit timing: quarter counter 0..CLK_DIV-1; each bit-time = quarters q0..q3.
//   Data/ack bit: q0,q1 scl=0 (SDA updated first cycle of q0); q2,q3 scl=1; sample last cycle of q3.
//   START: q0,q1 scl=1 SDA released; q2,q3 scl=1 SDA low.
//   STOP: q0,q1 scl=0 SDA low; q2 scl=1 SDA low; q3 scl=1 SDA released.
//  FSM: IDLE -> START -> ADDR (8 bits: addr[6..0] MSB first, then rw) -> ADDR_ACK (SDA released, sample)
//   ADDR_ACK: sampled 1 -> STOP, nack=1; else rw=0 -> WR_DATA, rw=1 -> RD_DATA.
//   WR_DATA: 8 bits, txData[7] first -> WR_ACK: release, sample -> nack=sample; -> STOP.
//   RD_DATA: SDA released, 8 samples shifted MSB first -> MST_NACK: SDA released (NACK) -> STOP.
//   STOP -> IDLE: busy=0 and done=1 on the same cycle, one cycle after STOP q3 ends; rxData updated then.
//  Accept: start=1 in IDLE on cycle t -> busy=1 and START q0 at t+1. start while busy ignored.
//  Full transfer = 20 bit-times = 80*CLK_DIV cycles of busy, regardless of rw.
//  Address NACK: 20 bit-times still elapse? No: STOP follows ADDR_ACK directly (11 bit-times).
//  nack cleared on accept; rxData holds last value on write or NACKed transfers.
//  Bit counter 3 bits, wraps 7->0 on phase change; quarter counter width $clog2(CLK_DIV).
// STRUCTURE
//  twi_defs.vh (shared with twi_slave): FSM state localparams, quarter-phase encodings.
//  Sub-module twi_bit_timer: quarter counter; emits qTick (last cycle of quarter) and quarter[1:0].
//  twi_master holds FSM, shift registers, synchronizer, output regs.
// TESTING (bench pairs DUT with twi_slave ADDR=7'h11, CLK_DIV=4, pull-up model on SDA)
//  write addr=0x11 txData=0xA5 -> slave dataIn=0xA5; done after 320 busy cycles; nack=0.
//  read addr=0x11, slave dataOut=0x3C -> rxData=0x3C, nack=0, 320 busy cycles, SDA high at 9th ack bit.
//  write addr=0x22 (no responder) -> nack=1, busy 176 cycles (11 bit-times), slave dataIn unchanged.
//  start pulsed again mid-transfer with addr=0x22 -> ignored; first transfer completes unchanged.
//  reset asserted mid-WR_DATA -> next cycle scl=1, sdaOutEn=0, busy=0; new write 0x5A completes after slave resync.
//  back-to-back: start on the cycle after done -> accepted; SDA/SCL high >=1 cycle between STOP and START.

Source files
------------

// File: rtl/twi_master_pkg.sv
// Shared definitions for the single-byte TWI initiator: FSM states and
// quarter-phase encodings of a bit-time.
package twi_master_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_MST_NACK,
        ST_STOP
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Open-drain drive: a 0 data bit pulls SDA low, a 1 releases it.
    function automatic logic pull_for(input logic bit_val);
        return !bit_val;
    endfunction

endpackage

// File: rtl/twi_master_bit_timer.sv
// Quarter bit-time generator. Counts 0..CLK_DIV-1 within each quarter and
// steps the quarter index 0..3; idles at zero while not enabled so every
// transfer starts at the first cycle of q0.
module twi_master_bit_timer
    import twi_master_pkg::*;
#(
    parameter int CLK_DIV = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic       q_tick,
    output logic [1:0] quarter
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    assign q_tick = en && (count == LAST);

    // Quarter counter; cleared whenever the bus is not in a transfer.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            count   <= '0;
            quarter <= Q0;
        end else if (count == LAST) begin
            count   <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            count   <= count + 1'b1;
        end
    end

endmodule

// File: rtl/twi_master.sv
// Single-byte TWI initiator: START, address + R/W, one data byte (written,
// or read and NACKed), STOP. SDA is open-drain (sdaOutEn pulls low).
//
//  state       | meaning
//  ------------+-----------------------------------------------
//  ST_IDLE     | bus released, waiting for start
//  ST_START    | START condition (SDA falls while SCL high)
//  ST_ADDR     | 7 address bits then R/W, MSB first
//  ST_ADDR_ACK | SDA released, target acknowledge sampled
//  ST_WR_DATA  | 8 write-data bits, MSB first
//  ST_WR_ACK   | SDA released, target acknowledge sampled
//  ST_RD_DATA  | SDA released, 8 bits sampled MSB first
//  ST_MST_NACK | SDA released to NACK the read byte
//  ST_STOP     | STOP condition (SDA rises while SCL high)
module twi_master
    import twi_master_pkg::*;
#(
    parameter int CLK_DIV = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] txData,
    output logic [7:0] rxData,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       scl,
    input  logic       sdaIn,
    output logic       sdaOut,
    output logic       sdaOutEn
);

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [7:0] tx_byte;
    logic [7:0] rx_shift;
    logic       rw_l;
    logic       sda_meta;
    logic       sda_sync;
    logic       q_tick;
    logic [1:0] quarter;
    logic       bit_end;

    assign sdaOut  = 1'b0;
    assign bit_end = q_tick && (quarter == Q3);

    twi_master_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .en      (busy),
        .q_tick  (q_tick),
        .quarter (quarter)
    );

    // Two-flop synchronizer for the asynchronous SDA pad; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            sda_meta <= sdaIn;
            sda_sync <= sda_meta;
        end
    end

    // Transfer FSM; pad drives are set on the edge that enters each quarter
    // so SCL/SDA change on the first cycle of the new phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
            tx_byte  <= 8'h00;
            rx_shift <= 8'h00;
            rw_l     <= 1'b0;
            rxData   <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
            scl      <= 1'b1;
            sdaOutEn <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    state    <= ST_START;
                    busy     <= 1'b1;
                    nack     <= 1'b0;
                    tx_shift <= {addr, rw};
                    tx_byte  <= txData;
                    rw_l     <= rw;
                    bit_cnt  <= 3'd0;
                    scl      <= 1'b1;
                    sdaOutEn <= 1'b0;
                end
            end else begin
                if (q_tick && (quarter == Q1)) begin
                    scl <= 1'b1;
                    if (state == ST_START) sdaOutEn <= 1'b1;
                end
                if (q_tick && (quarter == Q2) && (state == ST_STOP)) begin
                    sdaOutEn <= 1'b0;
                end
                if (bit_end) begin
                    scl <= 1'b0;
                    case (state)
                        ST_START: begin
                            state    <= ST_ADDR;
                            sdaOutEn <= pull_for(tx_shift[7]);
                        end
                        ST_ADDR: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state    <= ST_ADDR_ACK;
                                sdaOutEn <= 1'b0;
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                sdaOutEn <= pull_for(tx_shift[6]);
                            end
                        end
                        ST_ADDR_ACK: begin
                            if (sda_sync) begin
                                state    <= ST_STOP;
                                nack     <= 1'b1;
                                sdaOutEn <= 1'b1;
                            end else if (!rw_l) begin
                                state    <= ST_WR_DATA;
                                tx_shift <= tx_byte;
                                sdaOutEn <= pull_for(tx_byte[7]);
                            end else begin
                                state    <= ST_RD_DATA;
                                sdaOutEn <= 1'b0;
                            end
                        end
                        ST_WR_DATA: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state    <= ST_WR_ACK;
                                sdaOutEn <= 1'b0;
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                sdaOutEn <= pull_for(tx_shift[6]);
                            end
                        end
                        ST_WR_ACK: begin
                            nack     <= sda_sync;
                            state    <= ST_STOP;
                            sdaOutEn <= 1'b1;
                        end
                        ST_RD_DATA: begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            rx_shift <= {rx_shift[6:0], sda_sync};
                            sdaOutEn <= 1'b0;
                            if (bit_cnt == 3'd7) state <= ST_MST_NACK;
                        end
                        ST_MST_NACK: begin
                            state    <= ST_STOP;
                            sdaOutEn <= 1'b1;
                        end
                        ST_STOP: begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            scl      <= 1'b1;
                            sdaOutEn <= 1'b0;
                            // A NACKed read never shifted in a byte; keep the old one.
                            if (rw_l && !nack) rxData <= rx_shift;
                        end
                        default: begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            scl      <= 1'b1;
                            sdaOutEn <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_twi_master.sv
// Bench for twi_master: behavioural TWI target at address 0x11 on a pulled-up
// SDA line, transfers driven as directed steps, results checked against a
// scoreboard of expected completions.
module tb_twi_master;

    localparam int CLK_DIV = 4;
    localparam logic [6:0] SLV_ADDR = 7'h11;

    localparam int P_IDLE  = 0;
    localparam int P_ADDR  = 1;
    localparam int P_AACK  = 2;
    localparam int P_WRITE = 3;
    localparam int P_WACK  = 4;
    localparam int P_READ  = 5;

    typedef struct {
        logic       nack;
        logic [7:0] rx;
        int         cycles;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr = 7'h00;
    logic       rw = 1'b0;
    logic [7:0] txData = 8'h00;
    logic [7:0] rxData;
    logic       busy;
    logic       done;
    logic       nack;
    logic       scl;
    logic       sdaOut;
    logic       sdaOutEn;
    logic       sda_line;

    logic       slv_low = 1'b0;
    int         s_phase = P_IDLE;
    int         s_bits = 0;
    logic [7:0] s_shift = 8'h00;
    logic [7:0] s_din = 8'h00;
    logic [7:0] s_dout = 8'h3C;
    logic       s_rw = 1'b0;
    logic       s_mack = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    assign sda_line = !((sdaOutEn && (sdaOut == 1'b0)) || slv_low);

    always #5 clk = ~clk;

    twi_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .addr     (addr),
        .rw       (rw),
        .txData   (txData),
        .rxData   (rxData),
        .busy     (busy),
        .done     (done),
        .nack     (nack),
        .scl      (scl),
        .sdaIn    (sda_line),
        .sdaOut   (sdaOut),
        .sdaOutEn (sdaOutEn)
    );

    // Behavioural target: reacts to bus edges seen on the falling clock edge.
    always @(negedge clk) begin
        prev_scl <= scl;
        prev_sda <= sda_line;
        if (scl && prev_scl && prev_sda && !sda_line) begin
            s_phase <= P_ADDR;
            s_bits  <= 0;
            slv_low <= 1'b0;
        end else if (scl && prev_scl && !prev_sda && sda_line) begin
            s_phase <= P_IDLE;
            slv_low <= 1'b0;
        end else if (!prev_scl && scl) begin
            case (s_phase)
                P_ADDR, P_WRITE: begin
                    s_shift <= {s_shift[6:0], sda_line};
                    s_bits  <= s_bits + 1;
                end
                P_READ: begin
                    if (s_bits == 8) begin
                        s_mack  <= sda_line;
                        s_phase <= P_IDLE;
                    end else begin
                        s_bits <= s_bits + 1;
                    end
                end
                default: ;
            endcase
        end else if (prev_scl && !scl) begin
            case (s_phase)
                P_ADDR: begin
                    if (s_bits == 8) begin
                        if (s_shift[7:1] == SLV_ADDR) begin
                            slv_low <= 1'b1;
                            s_rw    <= s_shift[0];
                            s_phase <= P_AACK;
                        end else begin
                            s_phase <= P_IDLE;
                        end
                    end
                end
                P_AACK: begin
                    s_bits <= 0;
                    if (s_rw) begin
                        s_phase <= P_READ;
                        slv_low <= !s_dout[7];
                    end else begin
                        s_phase <= P_WRITE;
                        slv_low <= 1'b0;
                    end
                end
                P_WRITE: begin
                    if (s_bits == 8) begin
                        s_din   <= s_shift;
                        slv_low <= 1'b1;
                        s_phase <= P_WACK;
                    end
                end
                P_WACK: begin
                    slv_low <= 1'b0;
                    s_phase <= P_IDLE;
                end
                P_READ: slv_low <= (s_bits < 8) ? !s_dout[3'(7 - s_bits)] : 1'b0;
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One transfer: push the expected outcome, pulse start, count busy cycles
    // until done. poke >= 0 re-pulses start (addr 0x22) that many cycles in.
    task automatic run_xfer(input logic [6:0] a, input logic r, input logic [7:0] d,
                            input int exp_cycles, input logic exp_nack,
                            input logic [7:0] exp_rx, input int poke);
        exp_t e;
        exp_t got;
        int   cycles;
        int   guard;
        e.nack = exp_nack;
        e.rx = exp_rx;
        e.cycles = exp_cycles;
        sb.push_back(e);
        @(posedge clk); #1;
        addr = a;
        rw = r;
        txData = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_nack_clear", nack, 0);
        cycles = 0;
        guard = 0;
        while (!done && guard < 2000) begin
            if (busy) cycles++;
            if (guard == poke) begin
                addr = 7'h22;
                start = 1'b1;
            end else if (guard == poke + 1) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("sb_nonempty", sb.size(), 1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk("busy_cycles", cycles, got.cycles);
            chk("nack", nack, got.nack);
            chk("rxData", rxData, got.rx);
        end
        chk("bus_idle_scl", scl, 1);
        chk("bus_idle_sda", sda_line, 1);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", scl, 1);
        chk("rst_sdaOutEn", sdaOutEn, 0);
        chk("rst_sdaOut", sdaOut, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nack", nack, 0);
        chk("rst_rxData", rxData, 8'h00);
        reset = 1'b0;
        @(posedge clk); #1;

        run_xfer(7'h11, 1'b0, 8'hA5, 320, 1'b0, 8'h00, -1);
        chk("wr_slave_din", s_din, 8'hA5);

        run_xfer(7'h11, 1'b1, 8'h00, 320, 1'b0, 8'h3C, -1);
        chk("rd_master_nack_bit", s_mack, 1);

        run_xfer(7'h22, 1'b0, 8'h77, 176, 1'b1, 8'h3C, -1);
        chk("nack_slave_din_kept", s_din, 8'hA5);

        run_xfer(7'h11, 1'b0, 8'h69, 320, 1'b0, 8'h3C, 40);
        chk("poke_slave_din", s_din, 8'h69);

        // Reset in the middle of the write-data byte.
        @(posedge clk); #1;
        addr = 7'h11;
        rw = 1'b0;
        txData = 8'hC3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_scl", scl, 1);
        chk("midrst_sdaOutEn", sdaOutEn, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rxData", rxData, 8'h00);
        reset = 1'b0;
        chk("midrst_slave_din", s_din, 8'h69);

        run_xfer(7'h11, 1'b0, 8'h5A, 320, 1'b0, 8'h00, -1);
        chk("resync_slave_din", s_din, 8'h5A);

        // Back-to-back: each start raised on the cycle after the previous done.
        s_dout = 8'hC3;
        run_xfer(7'h11, 1'b1, 8'h00, 320, 1'b0, 8'hC3, -1);
        run_xfer(7'h11, 1'b0, 8'h0F, 320, 1'b0, 8'hC3, -1);
        chk("b2b_slave_din", s_din, 8'h0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
